bits_written: RTL and testbench
===============================

BITS_WRITTEN -- requirements
Module: bits_written

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the outstanding 0xFF-byte counter.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 in_valid  in  1  bin-update request.
REQ-005 in_ready  out  1  update accepted when in_valid&&in_ready.
REQ-006 shift  in  3  renorm shift, 0..7.
REQ-007 add_val  in  16  value added to low after shift; caller pre-shifts it.
REQ-008 flush  in  1  end-of-slice termination; sampled only on accept.
REQ-009 out_valid  out  1  output byte valid.
REQ-010 out_ready  in  1  sink accepts when out_valid&&out_ready.
REQ-011 out_byte  out  8  emitted bits, MSB-aligned.
REQ-012 out_nbits  out  4  valid bits in out_byte (8 except final fragment).
REQ-013 out_last  out  1  marks the final transfer of a flush.
REQ-014 ovf_err  out  1  sticky; outstanding counter saturated.

Function
REQ-015 SHALL hold low[31:0], bits_left (signed 6b), buf_byte[7:0] and cnt[CNT_W-1:0].
REQ-016 On accept: low_t = ((low<<shift)+add_val) mod 2^32; bl_t = bits_left-shift.
REQ-017 If bl_t>=12: low<=low_t, bits_left<=bl_t, no output.
REQ-018 If bl_t<12: lead[8:0] = low_t>>(24-bl_t); bits_left<=bl_t+8; low<=low_t & (0xFFFFFFFF>>(bl_t+8)).
REQ-019 lead==0xFF: cnt<=cnt+1, no output, in_ready stays 1.
REQ-020 lead!=0xFF, cnt==0: buf_byte<=lead[7:0], cnt<=1, no output.
REQ-021 lead!=0xFF, cnt>0: emit (buf_byte+lead[8])&0xFF, then cnt-1 bytes of (0xFF+lead[8])&0xFF; buf_byte<=lead[7:0], cnt<=1.
REQ-022 FSM states: IDLE, EMIT_HEAD, EMIT_RUN, FLUSH_HEAD, FLUSH_RUN, FLUSH_TAIL.
REQ-023 in_ready SHALL be 1 only in IDLE; 0 in every other state.
REQ-024 First out_valid SHALL appear the cycle after accept; one byte per out handshake, zero bubbles.
REQ-025 out_byte/out_nbits/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-026 After the last EMIT_RUN handshake, FSM SHALL return to IDLE; in_ready=1 next cycle.
REQ-027 flush with in_valid: REQ-016..021 update applied first, then the flush on the updated state.
REQ-028 Flush carry c = (low>>(32-bits_left))!=0.
REQ-029 Flush, c=1: if cnt>0, emit buf_byte+1, then cnt-1 bytes 0x00; low -= 1<<(32-bits_left).
REQ-030 Flush, c=0: if cnt>0, emit buf_byte, then cnt-1 bytes 0xFF.
REQ-031 FLUSH_TAIL: n=24-bits_left bits of low>>8, MSB first; n>8 emits a full byte, then n-8 bits; out_nbits=n mod fragment; out_last=1 on final transfer.
REQ-032 After the out_last handshake, state SHALL return to reset values (REQ-036) and IDLE.
REQ-033 cnt==2^CNT_W-1 and lead==0xFF: cnt SHALL saturate and ovf_err SHALL set; it is cleared only by reset.
REQ-034 shift==0 with add_val==0 SHALL be a legal no-op accept.

Reset
REQ-035 rst_n low at a clk edge SHALL abort any state, including mid-emission, and discard the pending byte.
REQ-036 Reset values: low=0, bits_left=23, buf_byte=0xFF, cnt=0, IDLE, in_ready=1, out_valid=0, out_byte=0, out_nbits=0, out_last=0, ovf_err=0.

Verification
REQ-037 Reset then idle: in_ready=1, out_valid=0; accept shift=7, add=0 -> bits_left=16, no output.
REQ-038 From reset: (shift7,add0x4000), then (shift5,add0) -> lead 0x40, buf=0x40, cnt=1, bits_left=19, low=0, no output.
REQ-039 Continue: (shift3,add0xFF00), then (shift5,add0) -> lead 0xFF, cnt=2, no output.
REQ-040 Continue: (shift2,add0x8000), then (shift6,add0), out_ready low 3 cycles -> stable 0x41, then 0x00; buf=0x00, cnt=1, in_ready back after 2nd handshake.
REQ-041 Continue: flush -> 0x00 (nbits 8), then 0x00 (nbits 5, out_last=1); then reset values.
REQ-042 Assert rst_n low while EMIT_RUN out_valid=1 -> next cycle out_valid=0, in_ready=1, all REQ-036 values.

Source files
------------

// File: rtl/bits_written.sv
// bits_written: output stage of a binary arithmetic encoder.
//
// Each accepted bin update shifts the low register, adds the caller's
// pre-shifted value and, once fewer than 12 bits are left, peels off a 9-bit
// lead (8 data bits plus a carry). Bytes are held back while a carry could
// still ripple into them: one buffered byte plus a count of pending 0xFF
// bytes. A non-0xFF lead resolves the carry and releases the buffered byte
// and its run. A flush resolves the final carry, releases the buffered bytes
// and then emits the remaining bits of low, MSB first, with a short final
// fragment.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   update request; accepted when both are high
//   shift[2:0]            renormalisation shift, 0..7
//   add_val[15:0]         value added to low after the shift
//   flush                 end-of-slice termination, sampled on accept
//   out_valid / out_ready output byte handshake
//   out_byte[7:0]         emitted bits, MSB-aligned
//   out_nbits[3:0]        number of valid bits in out_byte
//   out_last              final transfer of a flush
//   ovf_err               sticky: the 0xFF-run counter saturated
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never depends on ready, and while valid is high and ready is low
// the payload (out_byte/out_nbits/out_last) holds its value.
module bits_written #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  shift,
  input  logic [15:0] add_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic [3:0]  out_nbits,
  output logic        out_last,
  output logic        ovf_err
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT_HEAD,
    EMIT_RUN,
    FLUSH_HEAD,
    FLUSH_RUN,
    FLUSH_TAIL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_d;
  logic [31:0]       low, low_d;
  logic signed [5:0] bits_left, bits_left_d;
  logic [7:0]        buf_byte, buf_byte_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  // run bytes still to be sent after the byte currently presented
  logic [CNT_W-1:0]  run_left, run_left_d;
  logic [7:0]        run_byte, run_byte_d;
  // a flush arrived together with an update that emits; run it afterwards
  logic              flush_pend, flush_pend_d;
  logic [7:0]        out_byte_d;
  logic [3:0]        out_nbits_d;
  logic              out_last_d;
  logic              ovf_err_d;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);

  // ---------------------------------------------------------------------
  // Bin update arithmetic (applies to the registered state)
  // ---------------------------------------------------------------------
  logic [31:0]       low_t;
  logic signed [5:0] bl_t;
  logic [8:0]        lead;
  logic [31:0]       upd_low;
  logic signed [5:0] upd_bl;
  logic [7:0]        upd_buf;
  logic [CNT_W-1:0]  upd_cnt;
  logic              upd_ovf;
  logic              upd_emit;
  logic [7:0]        upd_head;
  logic [7:0]        upd_run_byte;
  logic [CNT_W-1:0]  upd_run_n;

  always_comb begin
    low_t        = (low << shift) + {16'd0, add_val};
    bl_t         = bits_left - $signed({3'b000, shift});
    // bl_t stays within 5..23, so the unsigned view is safe for shifting
    lead         = 9'(low_t >> (6'd24 - $unsigned(bl_t)));
    upd_low      = low_t;
    upd_bl       = bl_t;
    upd_buf      = buf_byte;
    upd_cnt      = cnt;
    upd_ovf      = ovf_err;
    upd_emit     = 1'b0;
    upd_head     = buf_byte + {7'd0, lead[8]};
    upd_run_byte = lead[8] ? 8'h00 : 8'hFF;
    upd_run_n    = cnt - CNT_W'(1);
    if (bl_t < 6'sd12) begin
      upd_bl  = bl_t + 6'sd8;
      upd_low = low_t & (32'hFFFF_FFFF >> ($unsigned(bl_t) + 6'd8));
      if (lead == 9'h0FF) begin
        // a 0xFF byte may still receive a carry: only count it
        if (cnt == CNT_MAX) upd_ovf = 1'b1;
        else                upd_cnt = cnt + CNT_W'(1);
      end else if (cnt == '0) begin
        upd_buf = lead[7:0];
        upd_cnt = CNT_W'(1);
      end else begin
        upd_emit = 1'b1;
        upd_buf  = lead[7:0];
        upd_cnt  = CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Flush arithmetic. In IDLE it sees the state the current update is
  // about to produce; otherwise it sees the registers.
  // ---------------------------------------------------------------------
  logic [31:0]       src_low;
  logic signed [5:0] src_bl;
  logic [7:0]        src_buf;
  logic [CNT_W-1:0]  src_cnt;
  logic [5:0]        fl_pos;
  logic              fl_carry;
  logic [31:0]       fl_low;
  logic [7:0]        fl_head;
  logic [7:0]        fl_run_byte;
  logic [5:0]        tail_n;
  logic [11:0]       tail_val;
  logic [7:0]        t1_byte;
  logic [3:0]        t1_nbits;
  logic              t1_last;
  logic [7:0]        t2_byte;
  logic [3:0]        t2_nbits;

  always_comb begin
    src_low     = in_ready ? upd_low : low;
    src_bl      = in_ready ? upd_bl  : bits_left;
    src_buf     = in_ready ? upd_buf : buf_byte;
    src_cnt     = in_ready ? upd_cnt : cnt;
    fl_pos      = 6'd32 - $unsigned(src_bl);
    fl_carry    = (src_low >> fl_pos) != 32'd0;
    fl_low      = fl_carry ? (src_low - (32'd1 << fl_pos)) : src_low;
    fl_head     = src_buf + {7'd0, fl_carry};
    fl_run_byte = fl_carry ? 8'h00 : 8'hFF;
    // remaining payload: tail_n (1..12) bits of low>>8; the carry bit sits
    // above them, so the subtraction above never changes these bits
    tail_n      = 6'd24 - $unsigned(src_bl);
    tail_val    = 12'(src_low >> 8) & (12'hFFF >> (6'd12 - tail_n));
    if (tail_n > 6'd8) begin
      t1_byte  = 8'(tail_val >> (tail_n - 6'd8));
      t1_nbits = 4'd8;
      t1_last  = 1'b0;
    end else begin
      t1_byte  = 8'(tail_val << (6'd8 - tail_n));
      t1_nbits = tail_n[3:0];
      t1_last  = 1'b1;
    end
    // second fragment: low (tail_n-8) bits, MSB-aligned
    t2_byte  = 8'(tail_val << (6'd16 - tail_n));
    t2_nbits = 4'(tail_n - 6'd8);
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------
  logic enter_flush;
  logic load_tail;
  logic go_idle;

  always_comb begin
    state_d      = state;
    low_d        = low;
    bits_left_d  = bits_left;
    buf_byte_d   = buf_byte;
    cnt_d        = cnt;
    run_left_d   = run_left;
    run_byte_d   = run_byte;
    flush_pend_d = flush_pend;
    out_byte_d   = out_byte;
    out_nbits_d  = out_nbits;
    out_last_d   = out_last;
    ovf_err_d    = ovf_err;
    enter_flush  = 1'b0;
    load_tail    = 1'b0;
    go_idle      = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          low_d       = upd_low;
          bits_left_d = upd_bl;
          buf_byte_d  = upd_buf;
          cnt_d       = upd_cnt;
          ovf_err_d   = upd_ovf;
          if (upd_emit) begin
            state_d      = EMIT_HEAD;
            out_byte_d   = upd_head;
            out_nbits_d  = 4'd8;
            out_last_d   = 1'b0;
            run_left_d   = upd_run_n;
            run_byte_d   = upd_run_byte;
            flush_pend_d = flush;
          end else if (flush) begin
            enter_flush = 1'b1;
          end
        end
      end
      EMIT_HEAD, EMIT_RUN: begin
        if (out_ready) begin
          if (run_left != '0) begin
            state_d    = EMIT_RUN;
            out_byte_d = run_byte;
            run_left_d = run_left - CNT_W'(1);
          end else if (flush_pend) begin
            enter_flush = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      FLUSH_HEAD, FLUSH_RUN: begin
        if (out_ready) begin
          if (run_left != '0) begin
            state_d    = FLUSH_RUN;
            out_byte_d = run_byte;
            run_left_d = run_left - CNT_W'(1);
          end else begin
            load_tail = 1'b1;
          end
        end
      end
      FLUSH_TAIL: begin
        if (out_ready) begin
          if (out_last) begin
            // slice finished: back to the initial coder state; the
            // overflow flag stays sticky until rst_n
            go_idle      = 1'b1;
            low_d        = 32'd0;
            bits_left_d  = 6'sd23;
            buf_byte_d   = 8'hFF;
            cnt_d        = '0;
            run_left_d   = '0;
            run_byte_d   = 8'h00;
            flush_pend_d = 1'b0;
          end else begin
            out_byte_d  = t2_byte;
            out_nbits_d = t2_nbits;
            out_last_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_flush) begin
      flush_pend_d = 1'b0;
      low_d        = fl_low;
      if (src_cnt != '0) begin
        state_d     = FLUSH_HEAD;
        out_byte_d  = fl_head;
        out_nbits_d = 4'd8;
        out_last_d  = 1'b0;
        run_left_d  = src_cnt - CNT_W'(1);
        run_byte_d  = fl_run_byte;
      end else begin
        load_tail = 1'b1;
      end
    end

    if (load_tail) begin
      state_d     = FLUSH_TAIL;
      out_byte_d  = t1_byte;
      out_nbits_d = t1_nbits;
      out_last_d  = t1_last;
    end

    if (go_idle) begin
      state_d     = IDLE;
      out_byte_d  = 8'h00;
      out_nbits_d = 4'd0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      low        <= 32'd0;
      bits_left  <= 6'sd23;
      buf_byte   <= 8'hFF;
      cnt        <= '0;
      run_left   <= '0;
      run_byte   <= 8'h00;
      flush_pend <= 1'b0;
      out_byte   <= 8'h00;
      out_nbits  <= 4'd0;
      out_last   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      low        <= low_d;
      bits_left  <= bits_left_d;
      buf_byte   <= buf_byte_d;
      cnt        <= cnt_d;
      run_left   <= run_left_d;
      run_byte   <= run_byte_d;
      flush_pend <= flush_pend_d;
      out_byte   <= out_byte_d;
      out_nbits  <= out_nbits_d;
      out_last   <= out_last_d;
      ovf_err    <= ovf_err_d;
    end
  end

endmodule

// File: tb/tb_bits_written.sv
// Testbench for bits_written: directed scenarios plus randomized updates,
// checked against a bit-level reference model of the encoder output stage.
module tb_bits_written;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  shift = 3'd0;
  logic [15:0] add_val = 16'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic [3:0]  out_nbits;
  logic        out_last;
  logic        ovf_err;

  always #5 clk = ~clk;

  bits_written #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift     (shift),
    .add_val   (add_val),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_nbits (out_nbits),
    .out_last  (out_last),
    .ovf_err   (ovf_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];   // {byte, nbits, last}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint unsigned m_low;
  int m_bl;
  int m_buf;
  int m_cnt;
  bit m_ovf;

  function automatic void model_init(input bit keep_ovf);
    m_low = 0;
    m_bl  = 23;
    m_buf = 255;
    m_cnt = 0;
    if (!keep_ovf) m_ovf = 1'b0;
  endfunction

  function automatic void push_out(input int b, input int nb, input bit last);
    exp_q.push_back({8'(b), 4'(nb), last});
  endfunction

  function automatic void model_flush();
    bit c;
    int n;
    int k;
    int b;
    longint unsigned tv;
    bit bits[$];
    c = ((m_low >> (32 - m_bl)) != 0);
    if (m_cnt > 0) begin
      push_out(c ? ((m_buf + 1) & 255) : m_buf, 8, 1'b0);
      for (int i = 1; i < m_cnt; i++) push_out(c ? 0 : 255, 8, 1'b0);
    end
    if (c) m_low = (m_low - (64'd1 << (32 - m_bl))) & 64'hFFFF_FFFF;
    // remaining bits as a plain bit stream, packed into bytes MSB first
    n  = 24 - m_bl;
    tv = (m_low >> 8) & ((64'd1 << n) - 1);
    for (int i = n - 1; i >= 0; i--) bits.push_back(tv[i]);
    while (bits.size() > 0) begin
      k = 0;
      b = 0;
      while (k < 8 && bits.size() > 0) begin
        b = (b << 1) | int'(bits.pop_front());
        k++;
      end
      push_out(b << (8 - k), k, bits.size() == 0);
    end
    model_init(1'b1);
  endfunction

  function automatic void model_accept(input int sh, input int add, input bit fl);
    longint unsigned lt;
    int blt;
    int lead;
    lt  = ((m_low << sh) + longint'(add)) & 64'hFFFF_FFFF;
    blt = m_bl - sh;
    if (blt >= 12) begin
      m_low = lt;
      m_bl  = blt;
    end else begin
      lead  = int'((lt >> (24 - blt)) & 64'h1FF);
      m_bl  = blt + 8;
      m_low = lt & (64'hFFFF_FFFF >> (blt + 8));
      if (lead == 255) begin
        if (m_cnt == CNT_MAX) m_ovf = 1'b1;
        else m_cnt++;
      end else if (m_cnt == 0) begin
        m_buf = lead & 255;
        m_cnt = 1;
      end else begin
        push_out((m_buf + (lead >> 8)) & 255, 8, 1'b0);
        for (int i = 1; i < m_cnt; i++) push_out((255 + (lead >> 8)) & 255, 8, 1'b0);
        m_buf = lead & 255;
        m_cnt = 1;
      end
    end
    if (fl) model_flush();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_state(input string tag);
    check({tag, "_low"},  dut.low, 32'(m_low));
    check({tag, "_bl"},   32'(dut.bits_left), m_bl);
    check({tag, "_buf"},  32'(dut.buf_byte), m_buf);
    check({tag, "_cnt"},  32'(dut.cnt), m_cnt);
    check({tag, "_ovf"},  32'(ovf_err), 32'(m_ovf));
  endtask

  task automatic check_out_cleared(input string tag);
    check({tag, "_obyte"}, 32'(out_byte), 0);
    check({tag, "_onb"},   32'(out_nbits), 0);
    check({tag, "_olast"}, 32'(out_last), 0);
  endtask

  // called and returns at a falling edge
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    model_init(1'b0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_valid", 32'(out_valid), 0);
    check_out_cleared("rst");
    check_state("rst");
    rst_n = 1'b1;
  endtask

  task automatic accept(input int sh, input int add, input bit fl);
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    shift    = 3'(sh);
    add_val  = 16'(add);
    flush    = fl;
    model_accept(sh, add, fl);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    shift    = 3'd0;
    add_val  = 16'd0;
  endtask

  // consume expected bytes; out_ready held low for the first 'stall' cycles
  task automatic drain(input int stall, input bit rnd, input bit flushed);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      check("out_valid", 32'(out_valid), 1);
      check("busy_ready", 32'(in_ready), 0);
      check("out_data", 32'({out_byte, out_nbits, out_last}), 32'(exp_q[0]));
      if (cyc < stall)  out_ready = 1'b0;
      else if (rnd)     out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (out_ready) void'(exp_q.pop_front());
      cyc++;
    end
    out_ready = 1'b0;
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    check("idle_valid", 32'(out_valid), 0);
    check("idle_ready", 32'(in_ready), 1);
    check_state("idle");
    if (flushed) check_out_cleared("post_flush");
  endtask

  task automatic send(input int sh, input int add, input bit fl);
    accept(sh, add, fl);
    drain(0, 1'b1, fl);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sh;
    int add;
    int mode;
    bit fl;

    @(negedge clk);
    do_reset();

    // idle then a quiet update
    send(7, 0, 0);
    check("r37_bl", 32'(dut.bits_left), 16);

    // buffered lead, 0xFF run, carry resolution with back-pressure, flush
    do_reset();
    send(7, 'h4000, 0);
    send(5, 0, 0);
    check("r38_buf", 32'(dut.buf_byte), 'h40);
    check("r38_cnt", 32'(dut.cnt), 1);
    check("r38_bl",  32'(dut.bits_left), 19);
    send(3, 'hFF00, 0);
    send(5, 0, 0);
    check("r39_cnt", 32'(dut.cnt), 2);
    send(2, 'h8000, 0);
    accept(6, 0, 0);
    check("r40_head", 32'(out_byte), 'h41);
    drain(3, 1'b0, 1'b0);
    check("r40_buf", 32'(dut.buf_byte), 0);
    send(0, 0, 0);              // legal no-op
    accept(0, 0, 1);
    check("r41_first", 32'({out_byte, out_nbits}), 'h008);
    drain(0, 1'b0, 1'b1);

    // flush with a pending carry
    do_reset();
    send(7, 'h4000, 0);
    send(5, 0, 0);
    send(0, 'h2000, 1);

    // counter saturation, then an emitting update carrying the flush
    do_reset();
    send(7, 'h4000, 0);
    send(5, 0, 0);
    for (int i = 0; i < CNT_MAX; i++) begin
      send(3, 'hFF00, 0);
      send(5, 0, 0);
    end
    check("sat_cnt", 32'(dut.cnt), CNT_MAX);
    check("sat_ovf", 32'(ovf_err), 1);
    send(2, 'h8000, 0);
    accept(6, 0, 1);
    drain(0, 1'b1, 1'b1);
    check("sat_sticky", 32'(ovf_err), 1);

    // reset in the middle of a run
    do_reset();
    send(7, 'h4000, 0);
    send(5, 0, 0);
    send(3, 'hFF00, 0);
    send(5, 0, 0);
    send(2, 'h8000, 0);
    accept(6, 0, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("mid_valid", 32'(out_valid), 1);
    check("mid_run", 32'({out_byte, out_nbits, out_last}), 'h010);
    do_reset();
    check("post_rst_ovf", 32'(ovf_err), 0);

    // randomized updates
    for (int t = 0; t < 300; t++) begin
      sh   = $urandom_range(0, 7);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       add = $urandom_range(0, 65535);
        1:       add = 0;
        2:       add = 'hFF00 >> $urandom_range(0, 3);
        default: add = ($urandom_range(0, 255) << $urandom_range(0, 8)) & 'hFFFF;
      endcase
      fl = ($urandom_range(0, 9) == 0);
      send(sh, add, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
